// File: rtl/itof_pipe.sv
// 3-stage pipelined int32 -> IEEE-754 single converter, round-to-nearest-even.
// Define ITOF_INEXACT_EN to add the registered inexact output.
module itof_pipe #(
    parameter int STAGES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y
`ifdef ITOF_INEXACT_EN
    ,
    output logic        inexact
`endif
);

    if (STAGES != 3) begin : g_stages_check
        $error("itof_pipe: only STAGES = 3 is supported");
    end

    logic        adv;
    logic        ld;

    logic        v1_q, v1_d;
    logic        v2_q, v2_d;
    logic        v3_q, v3_d;

    logic        s1_q, s1_d;
    logic [31:0] a1_q, a1_d;
    logic        z1_q, z1_d;

    logic        s2_q, s2_d;
    logic        z2_q, z2_d;
    logic [30:0] n2_q, n2_d;
    logic [7:0]  e2_q, e2_d;

    logic [31:0] y_q, y_d;

    logic [4:0]  lz;
    logic [22:0] mant;
    logic        g;
    logic        st;
    logic        rnd;
    logic [23:0] sum;
    logic [7:0]  e3;

    assign adv       = ~v3_q | out_ready;
    // Data registers freeze on flush so y keeps its last value.
    assign ld        = adv & ~flush;
    assign in_ready  = adv;
    assign out_valid = v3_q;
    assign y         = y_q;

    always_comb begin
        lz = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (a1_q[i]) begin
                lz = 5'(31 - i);
            end
        end
    end

    always_comb begin
        mant = n2_q[30:8];
        g    = n2_q[7];
        st   = |n2_q[6:0];
        rnd  = g & (st | mant[0]);
        sum  = {1'b0, mant} + {23'b0, rnd};
        // A carry out of the mantissa leaves sum[22:0] at zero and bumps e.
        e3   = e2_q + {7'b0, sum[23]};
    end

    always_comb begin
        v1_d = v1_q;
        v2_d = v2_q;
        v3_d = v3_q;
        if (flush) begin
            v1_d = 1'b0;
            v2_d = 1'b0;
            v3_d = 1'b0;
        end else if (adv) begin
            v1_d = in_valid;
            v2_d = v1_q;
            v3_d = v2_q;
        end
    end

    always_comb begin
        s1_d = s1_q;
        a1_d = a1_q;
        z1_d = z1_q;
        s2_d = s2_q;
        z2_d = z2_q;
        n2_d = n2_q;
        e2_d = e2_q;
        y_d  = y_q;
        if (ld) begin
            s1_d = x[31];
            a1_d = x[31] ? (~x + 32'd1) : x;
            z1_d = (x == 32'd0);
            s2_d = s1_q;
            z2_d = z1_q;
            n2_d = 31'(a1_q << lz);
            e2_d = 8'd158 - {3'b0, lz};
            y_d  = z2_q ? '0 : {s2_q, e3, sum[22:0]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            s1_q <= 1'b0;
            a1_q <= '0;
            z1_q <= 1'b0;
            s2_q <= 1'b0;
            z2_q <= 1'b0;
            n2_q <= '0;
            e2_q <= '0;
            y_q  <= '0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            v3_q <= v3_d;
            s1_q <= s1_d;
            a1_q <= a1_d;
            z1_q <= z1_d;
            s2_q <= s2_d;
            z2_q <= z2_d;
            n2_q <= n2_d;
            e2_q <= e2_d;
            y_q  <= y_d;
        end
    end

`ifdef ITOF_INEXACT_EN
    logic ix_q, ix_d;

    always_comb begin
        ix_d = ix_q;
        if (ld) begin
            ix_d = g | st;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ix_q <= 1'b0;
        end else begin
            ix_q <= ix_d;
        end
    end

    assign inexact = ix_q;
`endif

endmodule
